// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// The IF/ID bubble is a NOP instruction paired with an all-ones PC marker.
package pipe_stage_skid_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] PC_BUBBLE    = 32'hffff_ffff;
  localparam logic [63:0] IF_ID_BUBBLE = {NOP, PC_BUBBLE};

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_occ(input pipe_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      MAIN:    n = 2'd1;
      BOTH:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and
// bubble insertion; SKID=1 adds a second entry so in_ready comes from a flop.
//
// Handshake: a payload moves upstream->stage on a rising edge where
// in_valid & in_ready, and stage->downstream where out_valid & out_ready.
// Once in_valid is raised, in_data must hold until accepted; out_data holds
// while out_valid & ~out_ready. Both transfers are evaluated on the same edge.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(IF_ID_BUBBLE),
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output pipe_state_e       state
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              accept, emit;

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occ       = state_occ(state_q);
  assign state     = state_q;

  // main_q returns to the bubble whenever the stage drains, so out_data is a
  // NOP whenever out_valid is low without needing an output mux.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = MAIN;
            main_d  = in_data;
          end
        end
        MAIN: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = BOTH;
          end else if (emit) begin
            state_d = EMPTY;
            main_d  = BUBBLE_DATA;
          end
        end
        BOTH: begin
          if (emit) begin
            state_d = MAIN;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID) begin : g_skid
    logic ready_q;

    // Registered ready: the stage can always absorb one more payload unless
    // it will be holding two, so out_ready never reaches in_ready in-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ready_q <= 1'b1;
      end else begin
        ready_q <= (state_d != BOTH);
      end
    end
    assign in_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_q <= BUBBLE_DATA;
      end else if (flush) begin
        skid_q <= BUBBLE_DATA;
      end else if (state_q == MAIN && accept && !emit) begin
        skid_q <= in_data;
      end else if (state_q == BOTH && emit) begin
        skid_q <= BUBBLE_DATA;
      end
    end
  end else begin : g_single
    assign in_ready = ~out_valid | out_ready;
    assign skid_q   = BUBBLE_DATA;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance driven side by
// side, each with its own expected-payload queue and output monitor.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int          W      = 64;
  localparam logic [63:0] BUBBLE = 64'h0000_0013_ffff_ffff;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [1:0]        in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]      in_data[2];
  logic [W-1:0]      out_data[2];
  logic [1:0]        occ[2];
  pipe_state_e       state[2];

  int                checks = 0;
  int                errors = 0;
  int                pending[2];

  logic [W-1:0]      vec[$];
  int                idx[2];
  logic [1:0]        acc;
  bit                rand_mode;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int g, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s side%0d: got %h expected %h", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : side
    pipe_stage_skid #(.DATA_W(W), .SKID(g != 0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .occ      (occ[g]),
      .state    (state[g])
    );

    // scoreboard + monitor, sampled mid-cycle
    logic [W-1:0] exp_q[$];
    logic         stall_q;
    logic [W-1:0] held_q;
    logic         exp_rdy;

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        stall_q = 1'b0;
        pending[g] = 0;
      end else begin
        chk("occ", g, 64'(occ[g]), 64'(exp_q.size()));
        chk("state", g, 64'(state[g]), 64'(exp_q.size()));
        chk("out_valid", g, 64'(out_valid[g]), 64'(exp_q.size() != 0));
        exp_rdy = (g != 0) ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready[g]);
        chk("in_ready", g, 64'(in_ready[g]), 64'(exp_rdy));
        if (stall_q) chk("out_hold", g, out_data[g], held_q);
        if (!out_valid[g]) begin
          chk("bubble", g, out_data[g], BUBBLE);
        end else if (out_ready[g] && exp_q.size() != 0) begin
          chk("out_data", g, out_data[g], exp_q.pop_front());
        end
        stall_q = out_valid[g] & ~out_ready[g] & ~flush;
        held_q  = out_data[g];
        if (flush) exp_q.delete();
        else if (in_valid[g] & in_ready[g]) exp_q.push_back(in_data[g]);
        pending[g] = exp_q.size();
      end
    end
  end

  // driver tasks
  task automatic drive();
    logic hold;
    for (int g = 0; g < 2; g++) begin
      hold = in_valid[g] & ~acc[g];
      if (acc[g]) idx[g]++;
      acc[g] = 1'b0;
      if (!hold) begin
        in_valid[g] = (idx[g] < vec.size()) && (!rand_mode || $urandom_range(0, 1) == 1);
        in_data[g]  = in_valid[g] ? vec[idx[g]] : '0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int g = 0; g < 2; g++) acc[g] = in_valid[g] & in_ready[g];
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input int n);
    vec.delete();
    vec.push_back(a);
    if (n > 1) vec.push_back(b);
    if (n > 2) vec.push_back(c);
    idx[0] = 0;
    idx[1] = 0;
    drive();
  endtask

  task automatic abandon();
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      idx[g]      = vec.size();
    end
    acc = '0;
  endtask

  task automatic chk_idle(input string name);
    for (int g = 0; g < 2; g++) begin
      chk({name, "_valid"}, g, 64'(out_valid[g]), 64'd0);
      chk({name, "_data"}, g, out_data[g], BUBBLE);
      chk({name, "_occ"}, g, 64'(occ[g]), 64'd0);
    end
  endtask

  initial begin
    int budget;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    acc       = '0;
    rand_mode = 1'b0;
    idx[0]    = 0;
    idx[1]    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    for (int g = 0; g < 2; g++) chk("reset_in_ready", g, 64'(in_ready[g]), 64'd1);
    rst_n = 1'b1;

    // streaming 1..100
    out_ready = '1;
    vec.delete();
    for (int i = 1; i <= 100; i++) vec.push_back(64'(i));
    idx[0] = 0;
    idx[1] = 0;
    drive();
    for (int i = 0; i < 100; i++) begin
      cycle();
      for (int g = 0; g < 2; g++) begin
        chk("stream_data", g, out_data[g], 64'(i + 1));
        chk("stream_occ", g, 64'(occ[g]), 64'd1);
      end
    end
    cycle();
    chk_idle("drained");

    // backpressure: A, B, C with out_ready low
    out_ready = '0;
    load(64'hA, 64'hB, 64'hC, 3);
    cycle();
    for (int g = 0; g < 2; g++) chk("bp_occ1", g, 64'(occ[g]), 64'd1);
    cycle();
    chk("bp_occ2", 1, 64'(occ[1]), 64'd2);
    chk("bp_rdy_low", 1, 64'(in_ready[1]), 64'd0);
    chk("bp_occ_single", 0, 64'(occ[0]), 64'd1);
    cycle();
    chk("bp_hold_occ", 1, 64'(occ[1]), 64'd2);
    chk("bp_c_stalled", 1, in_data[1], 64'hC);
    for (int g = 0; g < 2; g++) chk("bp_hold_a", g, out_data[g], 64'hA);
    out_ready = '1;
    #1;
    chk("rdy_indep", 1, 64'(in_ready[1]), 64'd0);
    chk("single_rdy_same_cycle", 0, 64'(in_ready[0]), 64'd1);
    cycle();
    for (int g = 0; g < 2; g++) chk("bp_out_b", g, out_data[g], 64'hB);
    cycle();
    for (int g = 0; g < 2; g++) chk("bp_out_c", g, out_data[g], 64'hC);
    cycle();
    chk_idle("bp_drained");

    // flush with the skid stage full and 0xD waiting
    out_ready = '0;
    load(64'h11, 64'h12, 64'hD, 3);
    cycle();
    cycle();
    chk("fl_full", 1, 64'(occ[1]), 64'd2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    abandon();
    chk_idle("flush");
    for (int g = 0; g < 2; g++) chk("flush_in_ready", g, 64'(in_ready[g]), 64'd1);
    out_ready = '1;
    cycle();
    cycle();
    for (int g = 0; g < 2; g++) chk("flush_no_d", g, 64'(out_valid[g]), 64'd0);

    // flush with same-cycle emit (delivered) and accept (discarded)
    load(64'h31, 64'h32, 64'h0, 2);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk_idle("flush_emit");
    cycle();
    for (int g = 0; g < 2; g++) chk("flush_drop", g, 64'(out_valid[g]), 64'd0);

    // asynchronous reset with the skid stage full
    out_ready = '0;
    load(64'h21, 64'h22, 64'h0, 2);
    cycle();
    cycle();
    chk("rst_full", 1, 64'(occ[1]), 64'd2);
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    abandon();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) chk("rst_in_ready", g, 64'(in_ready[g]), 64'd1);

    // random traffic with occasional flush, then drain
    vec.delete();
    for (int i = 0; i < 6000; i++) vec.push_back(64'h5A00_0000_0000_0000 | 64'(i));
    idx[0] = 0;
    idx[1] = 0;
    rand_mode = 1'b1;
    drive();
    for (int i = 0; i < 10000; i++) begin
      cycle();
      out_ready[0] = ($urandom_range(0, 1) == 1);
      out_ready[1] = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 63) == 0);
    end
    flush     = 1'b0;
    out_ready = '1;
    rand_mode = 1'b0;
    budget    = 20000;
    while ((idx[0] < vec.size() || idx[1] < vec.size() || out_valid != 2'b00) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_budget", 0, 64'(budget > 0), 64'd1);
    cycle();
    for (int g = 0; g < 2; g++) chk("pending", g, 64'(pending[g]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
